// File: rtl/addsub_arb_pkg.sv
// Shared types and reset constants for the add/subtract arbiter.
// Contents: FSM state enum, client-id type, reset values of the
// round-robin pointer and the result owner.
package addsub_arb_pkg;

  // IDLE: nothing in flight; RESP: a result is held for its owner
  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  // Identifies one of the two clients
  typedef logic client_id_t;

  // last = 1 after reset so client 0 wins the first tie
  localparam client_id_t LAST_RST  = 1'b1;
  localparam client_id_t OWNER_RST = 1'b0;

  // Client selected on a tie: whichever was not granted most recently
  function automatic client_id_t tie_winner(input client_id_t last);
    return client_id_t'(~last);
  endfunction

endpackage : addsub_arb_pkg

// File: rtl/addsub_cla.sv
// W-bit carry-lookahead adder/subtractor.
// Computes s = a + (b ^ {W{m}}) + m (mod 2^W).
// Ports:
//   a_i, b_i  : operands (W bits)
//   m_i       : mode, 0 = add, 1 = subtract
//   s_o       : result (W bits)
//   c_o       : carry out of bit W-1
//   v_o       : signed overflow (carry into MSB ^ carry out of MSB)
module addsub_cla #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         m_i,
  output logic [W-1:0] s_o,
  output logic         c_o,
  output logic         v_o
);

  logic [W-1:0] bx;
  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   carry;
  logic         acc;
  logic         prod;

  assign bx = b_i ^ {W{m_i}};
  assign g  = a_i & bx;
  assign p  = a_i ^ bx;

  // Each carry is the flat sum-of-products of lower generates and the
  // propagate chain, so no carry depends on the carry below it.
  always_comb begin
    carry    = '0;
    acc      = 1'b0;
    prod     = 1'b0;
    carry[0] = m_i;
    for (int i = 0; i < int'(W); i++) begin
      acc  = g[i];
      prod = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc  = acc | (prod & g[j]);
        prod = prod & p[j];
      end
      carry[i+1] = acc | (prod & m_i);
    end
  end

  assign s_o = p ^ carry[W-1:0];
  assign c_o = carry[W];
  assign v_o = carry[W] ^ carry[W-1];

endmodule : addsub_cla

// File: rtl/addsub_arbiter.sv
// Two-client round-robin arbiter sharing one addsub_cla datapath.
// Each client issues {a, b, m} over a valid/ready request channel and
// receives a registered result over its own valid/ready response channel.
// Only one operation is in flight; a new accept is possible once the
// previous result has been consumed.
// Ports:
//   clk, rst_n                       : clock, async active-low reset
//   reqN_valid/reqN_ready            : request handshake, client N
//   reqN_a, reqN_b, reqN_m           : operands and mode, client N
//   rspN_valid/rspN_ready            : response handshake, client N
//   rspN_s                           : result, client N
//   rspN_c, rspN_v                   : carry / overflow, client N
// Build option: define ADDSUB_ARB_FLAGS_EN to add the carry/overflow
// ports and their flops; without it only the sum is returned.
module addsub_arbiter
  import addsub_arb_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_m,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_m,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [W-1:0] rsp0_s,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp1_s
`ifdef ADDSUB_ARB_FLAGS_EN
  ,
  output logic         rsp0_c,
  output logic         rsp0_v,
  output logic         rsp1_c,
  output logic         rsp1_v
`endif
);

  state_e     state_q, state_d;
  client_id_t last_q,  last_d;
  client_id_t owner_q, owner_d;
  logic [W-1:0] s_q, s_d;

  logic         gnt_any_c;
  client_id_t   gnt_id_c;
  logic         rsp_hs_c;
  logic [W-1:0] cla_a;
  logic [W-1:0] cla_b;
  logic         cla_m;
  logic [W-1:0] cla_s;

`ifdef ADDSUB_ARB_FLAGS_EN
  logic c_q, c_d;
  logic v_q, v_d;
  logic cla_c;
  logic cla_v;
`else
  // Flags not needed in this build
  logic unused_cla_c;
  logic unused_cla_v;
`endif

  // Round-robin grant: a lone requester wins, a tie goes away from last
  always_comb begin
    gnt_any_c = req0_valid | req1_valid;
    gnt_id_c  = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt_id_c = tie_winner(last_q);
    end else if (req1_valid) begin
      gnt_id_c = 1'b1;
    end
  end

  // Operand mux into the shared datapath follows the current grant
  assign cla_a = gnt_id_c ? req1_a : req0_a;
  assign cla_b = gnt_id_c ? req1_b : req0_b;
  assign cla_m = gnt_id_c ? req1_m : req0_m;

  addsub_cla #(
    .W (W)
  ) u_cla (
    .a_i (cla_a),
    .b_i (cla_b),
    .m_i (cla_m),
    .s_o (cla_s),
`ifdef ADDSUB_ARB_FLAGS_EN
    .c_o (cla_c),
    .v_o (cla_v)
`else
    .c_o (unused_cla_c),
    .v_o (unused_cla_v)
`endif
  );

  // Response handshake of whichever client owns the held result
  assign rsp_hs_c = owner_q ? rsp1_ready : rsp0_ready;

  // State, owner and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= LAST_RST;
      owner_q <= OWNER_RST;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
    end
  end

  // Result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
`ifdef ADDSUB_ARB_FLAGS_EN
      c_q <= 1'b0;
      v_q <= 1'b0;
`endif
    end else begin
      s_q <= s_d;
`ifdef ADDSUB_ARB_FLAGS_EN
      c_q <= c_d;
      v_q <= v_d;
`endif
    end
  end

  // Next state: accept in IDLE, release on the owner's handshake in RESP
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    s_d     = s_q;
`ifdef ADDSUB_ARB_FLAGS_EN
    c_d     = c_q;
    v_d     = v_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (gnt_any_c) begin
          state_d = RESP;
          last_d  = gnt_id_c;
          owner_d = gnt_id_c;
          s_d     = cla_s;
`ifdef ADDSUB_ARB_FLAGS_EN
          c_d     = cla_c;
          v_d     = cla_v;
`endif
        end
      end
      RESP: begin
        if (rsp_hs_c) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: ready is a live grant (masked in reset), response side
  // decodes only registered state
  always_comb begin
    req0_ready = rst_n && (state_q == IDLE) && gnt_any_c && (gnt_id_c == 1'b0);
    req1_ready = rst_n && (state_q == IDLE) && gnt_any_c && (gnt_id_c == 1'b1);
    rsp0_valid = (state_q == RESP) && (owner_q == 1'b0);
    rsp1_valid = (state_q == RESP) && (owner_q == 1'b1);
    rsp0_s     = s_q;
    rsp1_s     = s_q;
`ifdef ADDSUB_ARB_FLAGS_EN
    rsp0_c     = c_q;
    rsp0_v     = v_q;
    rsp1_c     = c_q;
    rsp1_v     = v_q;
`endif
  end

endmodule : addsub_arbiter

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter (W = 4): directed scenarios plus
// a randomized run against a transaction-level reference model.
// Flag checks are active when ADDSUB_ARB_FLAGS_EN is defined.
module tb_addsub_arbiter;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req0_m;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_m;
  logic [W-1:0] req1_a, req1_b;
  logic         rsp0_valid, rsp0_ready;
  logic [W-1:0] rsp0_s;
  logic         rsp1_valid, rsp1_ready;
  logic [W-1:0] rsp1_s;
`ifdef ADDSUB_ARB_FLAGS_EN
  logic rsp0_c, rsp0_v, rsp1_c, rsp1_v;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  addsub_arbiter #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_m     (req0_m),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_m     (req1_m),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_s     (rsp0_s),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_s     (rsp1_s)
`ifdef ADDSUB_ARB_FLAGS_EN
    ,
    .rsp0_c     (rsp0_c),
    .rsp0_v     (rsp0_v),
    .rsp1_c     (rsp1_c),
    .rsp1_v     (rsp1_v)
`endif
  );

  // Reference arithmetic from integer sums/differences
  function automatic logic [W-1:0] ref_s(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    int r;
    r = m ? (int'(a) - int'(b)) : (int'(a) + int'(b));
    return W'(r & ((1 << W) - 1));
  endfunction

  function automatic logic ref_c(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    return m ? (a >= b) : ((int'(a) + int'(b)) >= (1 << W));
  endfunction

  function automatic logic ref_v(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    int sa, sb, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = m ? (sa - sb) : (sa + sb);
    return (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_m = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_m = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready got=%b exp=0", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_req1_ready got=%b exp=0", req1_ready); end
    cyc(); cyc();
    checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp0_valid got=%b exp=0", rsp0_valid); end
    checks++; if (rsp1_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp1_valid got=%b exp=0", rsp1_valid); end
    checks++; if (rsp0_s !== '0) begin errors++; $display("FAIL reset_rsp_s got=%h exp=0", rsp0_s); end
    rst_n = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL reset_first_tie_req0 got=%b exp=1", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_first_tie_req1 got=%b exp=0", req1_ready); end
    idle_inputs();
  endtask

  task automatic test_add();
    req0_valid = 1'b1; req0_a = 4'd5; req0_b = 4'd3; req0_m = 1'b0;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL add_ready got=%b exp=1", req0_ready); end
    cyc();
    req0_valid = 1'b0; req0_a = 4'd0; req1_valid = 1'b1;
    #1;
    checks++; if (rsp0_valid !== 1'b1) begin errors++; $display("FAIL add_rsp0_valid got=%b exp=1", rsp0_valid); end
    checks++; if (rsp1_valid !== 1'b0) begin errors++; $display("FAIL add_rsp1_valid got=%b exp=0", rsp1_valid); end
    checks++; if (rsp0_s !== 4'd8) begin errors++; $display("FAIL add_s got=%0d exp=8", rsp0_s); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL add_ready_in_resp got=%b exp=0", req1_ready); end
`ifdef ADDSUB_ARB_FLAGS_EN
    checks++; if (rsp0_c !== 1'b0) begin errors++; $display("FAIL add_c got=%b exp=0", rsp0_c); end
    checks++; if (rsp0_v !== 1'b1) begin errors++; $display("FAIL add_v got=%b exp=1", rsp0_v); end
`endif
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    cyc();
    rsp0_ready = 1'b0;
    checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL add_released got=%b exp=0", rsp0_valid); end
  endtask

  task automatic test_sub();
    req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd3; req1_m = 1'b1;
    #1;
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL sub_ready got=%b exp=1", req1_ready); end
    cyc();
    req1_valid = 1'b0;
    #1;
    checks++; if (rsp1_valid !== 1'b1) begin errors++; $display("FAIL sub_rsp1_valid got=%b exp=1", rsp1_valid); end
    checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL sub_rsp0_valid got=%b exp=0", rsp0_valid); end
    checks++; if (rsp1_s !== 4'd2) begin errors++; $display("FAIL sub_s got=%0d exp=2", rsp1_s); end
`ifdef ADDSUB_ARB_FLAGS_EN
    checks++; if (rsp1_c !== 1'b1) begin errors++; $display("FAIL sub_c got=%b exp=1", rsp1_c); end
    checks++; if (rsp1_v !== 1'b0) begin errors++; $display("FAIL sub_v got=%b exp=0", rsp1_v); end
`endif
    rsp1_ready = 1'b1;
    cyc();
    rsp1_ready = 1'b0;
    checks++; if (rsp1_valid !== 1'b0) begin errors++; $display("FAIL sub_released got=%b exp=0", rsp1_valid); end
  endtask

  task automatic test_reset_mid_resp();
    req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd1; req0_m = 1'b0;
    cyc();
    req0_valid = 1'b0;
    checks++; if (rsp0_valid !== 1'b1) begin errors++; $display("FAIL midrst_held got=%b exp=1", rsp0_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid_drop got=%b exp=0", rsp0_valid); end
    cyc();
    rst_n = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL midrst_tie_req0 got=%b exp=1", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL midrst_tie_req1 got=%b exp=0", req1_ready); end
    idle_inputs();
  endtask

  task automatic test_alternation();
    logic exp_id;
    pulse_reset();
    req0_valid = 1'b1; req0_a = 4'd7; req0_b = 4'd1; req0_m = 1'b0;
    req1_valid = 1'b1; req1_a = 4'd5; req1_b = 4'd3; req1_m = 1'b1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      exp_id = 1'((i / 2) % 2);
      if (i % 2 == 0) begin
        checks++; if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL alt_grant[%0d] got=%b%b exp_client=%0d", i, req1_ready, req0_ready, exp_id);
        end
      end else begin
        checks++; if ({rsp1_valid, rsp0_valid} !== (exp_id ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL alt_rsp_valid[%0d] got=%b%b exp_client=%0d", i, rsp1_valid, rsp0_valid, exp_id);
        end
        checks++; if (rsp0_s !== (exp_id ? 4'd2 : 4'd8)) begin
          errors++; $display("FAIL alt_s[%0d] got=%0d exp=%0d", i, rsp0_s, exp_id ? 2 : 8);
        end
`ifdef ADDSUB_ARB_FLAGS_EN
        checks++; if ({rsp0_c, rsp0_v} !== (exp_id ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL alt_flags[%0d] got=%b%b exp_client=%0d", i, rsp0_c, rsp0_v, exp_id);
        end
`endif
      end
      cyc();
    end
    idle_inputs();
    cyc();
  endtask

  task automatic test_backpressure();
    pulse_reset();
    req0_valid = 1'b1; req0_a = 4'd9; req0_b = 4'd9; req0_m = 1'b0;
    cyc();
    req0_a = 4'd1; req0_b = 4'd1;
    req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp0_valid !== 1'b1 || rsp0_s !== 4'd2) begin
        errors++; $display("FAIL bp_hold[%0d] valid=%b s=%0d exp valid=1 s=2", i, rsp0_valid, rsp0_s);
      end
`ifdef ADDSUB_ARB_FLAGS_EN
      checks++; if ({rsp0_c, rsp0_v} !== 2'b11) begin
        errors++; $display("FAIL bp_flags[%0d] got=%b%b exp=11", i, rsp0_c, rsp0_v);
      end
`endif
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++; $display("FAIL bp_ready[%0d] got=%b%b exp=00", i, req1_ready, req0_ready);
      end
      cyc();
    end
    rsp0_ready = 1'b1;
    cyc();
    rsp0_ready = 1'b0;
    checks++; if (rsp0_valid !== 1'b0 || req1_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release valid=%b req1_ready=%b exp 0/1", rsp0_valid, req1_ready);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    logic         busy, m_owner, m_last, m_c, m_v;
    logic [W-1:0] m_s;
    logic         e_r0, e_r1;
    pulse_reset();
    busy = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_s = '0; m_c = 1'b0; m_v = 1'b0;
    for (int n = 0; n < 400; n++) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      req0_a = W'($urandom); req0_b = W'($urandom); req0_m = 1'($urandom);
      req1_a = W'($urandom); req1_b = W'($urandom); req1_m = 1'($urandom);
      rsp0_ready = ($urandom_range(0, 2) != 0);
      rsp1_ready = ($urandom_range(0, 2) != 0);
      e_r0 = 1'b0; e_r1 = 1'b0;
      if (!busy) begin
        if (req0_valid && req1_valid) begin
          e_r0 = m_last; e_r1 = ~m_last;
        end else begin
          e_r0 = req0_valid; e_r1 = req1_valid;
        end
      end
      #1;
      checks++; if (req0_ready !== e_r0 || req1_ready !== e_r1) begin
        errors++; $display("FAIL rnd_ready[%0d] got=%b%b exp=%b%b", n, req1_ready, req0_ready, e_r1, e_r0);
      end
      checks++; if (rsp0_valid !== (busy && !m_owner) || rsp1_valid !== (busy && m_owner)) begin
        errors++; $display("FAIL rnd_rsp_valid[%0d] got=%b%b exp=%b%b", n, rsp1_valid, rsp0_valid,
                           busy && m_owner, busy && !m_owner);
      end
      if (busy) begin
        checks++; if ((m_owner ? rsp1_s : rsp0_s) !== m_s) begin
          errors++; $display("FAIL rnd_s[%0d] got=%0d exp=%0d", n, m_owner ? rsp1_s : rsp0_s, m_s);
        end
`ifdef ADDSUB_ARB_FLAGS_EN
        checks++; if ((m_owner ? {rsp1_c, rsp1_v} : {rsp0_c, rsp0_v}) !== {m_c, m_v}) begin
          errors++; $display("FAIL rnd_flags[%0d] exp=%b%b", n, m_c, m_v);
        end
`endif
      end
      if (e_r0 || e_r1) begin
        busy = 1'b1; m_owner = e_r1; m_last = e_r1;
        if (e_r1) begin
          m_s = ref_s(req1_a, req1_b, req1_m); m_c = ref_c(req1_a, req1_b, req1_m); m_v = ref_v(req1_a, req1_b, req1_m);
        end else begin
          m_s = ref_s(req0_a, req0_b, req0_m); m_c = ref_c(req0_a, req0_b, req0_m); m_v = ref_v(req0_a, req0_b, req0_m);
        end
      end else if (busy && (m_owner ? rsp1_ready : rsp0_ready)) begin
        busy = 1'b0;
      end
      cyc();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_reset_mid_resp();
    test_alternation();
    test_backpressure();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_addsub_arbiter

// File: doc/addsub_arbiter.md
# addsub_arbiter

Two-requester round-robin arbiter that shares a single W-bit carry-lookahead add/subtract datapath (`addsub_cla`) between two independent clients. Each client presents operands and a mode bit through a valid/ready request channel. Each client receives a registered sum with carry and overflow flags through its own valid/ready response channel. The block sits between the client controllers and the one shared adder instance, so the datapath is never driven by two sources at once.

## Interface
Parameters:
- W, 4, operand/result width in bits (W ≥ 2)

Ports:
- Clock and reset: single clock `clk`; reset `rst_n` is asynchronous and active-low.
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  client 0 request valid
- req0_ready  output  1  client 0 request accepted this cycle when high with req0_valid
- req0_a, req0_b  input  W  client 0 operands
- req0_m  input  1  client 0 mode: 0 = A+B, 1 = A−B
- req1_valid, req1_ready, req1_a, req1_b, req1_m: same as client 0, for client 1
- rsp0_valid  output  1  client 0 result valid
- rsp0_ready  input  1  client 0 result consumed
- rsp0_s  output  W  client 0 result
- rsp0_c, rsp0_v  output  1  client 0 carry-out and signed overflow (present only with ADDSUB_ARB_FLAGS_EN)
- rsp1_valid, rsp1_ready, rsp1_s, rsp1_c, rsp1_v: same as client 0, for client 1

## Operation
- FSM states:
  - IDLE: no operation in flight.
  - RESP: a result is held, owner recorded in `owner`.
- Round-robin pointer `last`: the id of the most recently granted client.
- Grant is computed in IDLE only:
  - If one client is valid, that client wins.
  - If both are valid, the client ≠ `last` wins.
- In IDLE, `reqX_ready` = grant to X. It depends combinationally on both valids. It is never high in RESP.
- On accept (ready & valid):
  - The winner's A, B and M are muxed into `addsub_cla`.
  - S, C and V are captured into the result register.
  - `owner` ← winner, `last` ← winner, state → RESP.
- In RESP:
  - `rspX_valid` = 1 only for X = `owner`.
  - S, C and V are held stable until `rspX_ready`.
  - On handshake, state → IDLE.
- The non-owner's `rsp_valid` stays 0 at all times.
- Arithmetic follows `addsub_cla` semantics:
  - S = A + (B ^ {W{M}}) + M, modulo 2^W.
  - C = carry out of bit W−1.
  - V = carry into bit W−1 XOR carry out of bit W−1.
- Operands are sampled only at accept. Changes afterward have no effect.
- A client that drops `valid` before being granted loses nothing. No request is queued.
- Reset (at any time, including mid-RESP):
  - state = IDLE, `last` = 1 (client 0 wins the first tie), `owner` = 0.
  - Result register = 0.
  - All `rsp*_valid` = 0 and all `req*_ready` = 0 while `rst_n` is low.
  - An in-flight result is discarded.

## Timing
- Latency: accept in cycle T → `rsp_valid` high from cycle T+1.
- The response handshake in cycle T+k → state is IDLE at T+k+1. The next accept is possible at T+k+1 at the earliest.
- Peak throughput is 1 operation per 2 cycles with `rsp_ready` held high.
- With both clients continuously valid and `rsp_ready` high, grants alternate 0,1,0,1… starting with client 0 after reset.
- `req_ready` may be high in the same cycle that `req_valid` first rises (no registered delay).
- Response outputs come from registers. No combinational path exists from `rsp_ready` to any `rsp` output.

## Configuration
- Macro `ADDSUB_ARB_FLAGS_EN`.
- Defined:
  - `rsp0_c`/`rsp0_v`/`rsp1_c`/`rsp1_v` exist.
  - C and V are registered with S.
- Undefined:
  - These four ports and their flag flops are absent.
  - The `addsub_cla` C/V outputs are left unconnected.
  - S behaviour and all timing are unchanged.

## Structure
- Shared package `addsub_arb_pkg`:
  - state enum {IDLE, RESP}
  - client-id type (1 bit)
  - reset constants LAST_RST = 1 and OWNER_RST = 0
- Sub-module: one instance of the existing `addsub_cla #(.W(W))`. The operand mux, arbiter, FSM and result register live in `addsub_arbiter`.

## Test plan
- Reset mid-RESP: client 0 accepted, hold rsp0_ready=0, pulse rst_n low → rsp0_valid=0 immediately; after release, the next tie is granted to client 0.
- Single client, add, W=4: req0 A=5, B=3, M=0 → rsp0_valid at T+1, S=8, C=0, V=1.
- Single client, subtract: req1 A=5, B=3, M=1 → rsp1_s=2, C=1, V=0; rsp0_valid stays 0.
- Tie alternation: both valid continuously (client 0: 7+1, client 1: 5−3), rsp ready high → grants 0,1,0,1; client 0 gets S=8, V=1; client 1 gets S=2, C=1.
- Backpressure: rsp0_ready low for 5 cycles after result → S/C/V stable, req0_ready and req1_ready low throughout; release → IDLE the next cycle.
- Flags compile-out: build without ADDSUB_ARB_FLAGS_EN, rerun the add and subtract cases → identical S values and cycle timing.
